// File: rtl/load_data_unit.sv
// Load result formatter: captures a load request beside the synchronous RAM read,
// then selects, extracts and extends the returning word. Define LOAD_MMIO_EN for the MMIO read path.
module load_data_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic        stall,
  input  logic [31:0] dmem_dout,
  input  logic [31:0] bios_dout,
  input  logic [31:0] mmio_dout,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        region_err
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RESP = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [1:0] REG_DMEM = 2'd0;
  localparam logic [1:0] REG_BIOS = 2'd1;
`ifdef LOAD_MMIO_EN
  localparam logic [1:0] REG_MMIO = 2'd2;
`endif
  localparam logic [1:0] REG_NONE = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [1:0]  r_region;
  logic        r_misaligned;
  logic [31:0] r_hold_data;
  logic        r_hold_mis;
  logic        r_hold_err;

  logic        w_accept;
  logic [1:0]  w_region;
  logic        w_misaligned;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic [31:0] w_fmt_data;
  logic        w_fmt_err;
  logic        w_unused_addr;

  // Only the region nibble and the byte offset matter to the load formatter.
  assign w_unused_addr = ^req_addr[27:2];
`ifndef LOAD_MMIO_EN
  logic w_unused_mmio;
  assign w_unused_mmio = ^mmio_dout;
`endif

  assign w_accept = req_valid & ~stall;

  always_comb begin
    case (req_addr[31:28])
      4'b0001, 4'b0011: w_region = REG_DMEM;
      4'b0100:          w_region = REG_BIOS;
`ifdef LOAD_MMIO_EN
      4'b1000:          w_region = REG_MMIO;
`endif
      default:          w_region = REG_NONE;
    endcase
  end

  // Undefined funct3 encodings behave as LW, including the alignment rule.
  always_comb begin
    case (req_funct3)
      3'b000, 3'b100: w_misaligned = 1'b0;
      3'b001, 3'b101: w_misaligned = req_addr[0];
      default:        w_misaligned = |req_addr[1:0];
    endcase
  end

  always_comb begin
    case (r_region)
      REG_DMEM: w_word = dmem_dout;
      REG_BIOS: w_word = bios_dout;
`ifdef LOAD_MMIO_EN
      REG_MMIO: w_word = mmio_dout;
`endif
      default:  w_word = 32'd0;
    endcase
  end

  always_comb begin
    case (r_off)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = r_off[1] ? w_word[31:16] : w_word[15:0];
    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = w_word;
    endcase
  end

  assign w_fmt_err  = ~r_misaligned & (r_region == REG_NONE);
  assign w_fmt_data = (r_misaligned | (r_region == REG_NONE)) ? 32'd0 : w_ext;

  always_comb begin
    load_valid = 1'b0;
    load_data  = 32'd0;
    misaligned = 1'b0;
    region_err = 1'b0;
    case (r_state)
      RESP: begin
        load_valid = 1'b1;
        load_data  = w_fmt_data;
        misaligned = r_misaligned;
        region_err = w_fmt_err;
      end
      HOLD: begin
        load_valid = 1'b1;
        load_data  = r_hold_data;
        misaligned = r_hold_mis;
        region_err = r_hold_err;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = IDLE;
    case (r_state)
      IDLE:    w_state_next = w_accept ? RESP : IDLE;
      RESP:    w_state_next = stall ? HOLD : (req_valid ? RESP : IDLE);
      HOLD:    w_state_next = stall ? HOLD : (req_valid ? RESP : IDLE);
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_funct3     <= 3'd0;
      r_off        <= 2'd0;
      r_region     <= REG_DMEM;
      r_misaligned <= 1'b0;
      r_hold_data  <= 32'd0;
      r_hold_mis   <= 1'b0;
      r_hold_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_funct3     <= req_funct3;
        r_off        <= req_addr[1:0];
        r_region     <= w_region;
        r_misaligned <= w_misaligned;
      end
      // Freeze the live result on the first stalled cycle so RAM churn cannot leak out.
      if (r_state == RESP && stall) begin
        r_hold_data <= w_fmt_data;
        r_hold_mis  <= r_misaligned;
        r_hold_err  <= w_fmt_err;
      end
    end
  end
endmodule

// File: doc/load_data_unit.md
# load_data_unit

Load-side counterpart to the store path of the memory stage. It captures the load request alongside the synchronous-read block RAM address and selects the returning word from DMEM, BIOS or MMIO one cycle later. It then extracts and sign/zero-extends the byte, halfword or word for LB/LH/LW/LBU/LHU and holds the result stable across pipeline stalls. It sits between the memory block's RAM read ports and the writeback mux.

## Interface
- No parameters.
- `clk` in 1 — core clock; all state updates on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `req_valid` in 1 — a load is issued this cycle; its address is being presented to the RAMs this cycle.
- `req_funct3` in 3 — RV32I load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `req_addr` in 32 — byte address of the load.
- `stall` in 1 — pipeline hold; no new request accepted, output held.
- `dmem_dout` in 32 — DMEM read data, valid the cycle after its address.
- `bios_dout` in 32 — BIOS port-B read data, same latency.
- `mmio_dout` in 32 — MMIO read data, same latency.
- `load_valid` out 1 — load_data is a completed load result.
- `load_data` out 32 — extended load result.
- `misaligned` out 1 — result belongs to a misaligned load; load_data = 0.
- `region_err` out 1 — result belongs to an unmapped address; load_data = 0.

## Operation
- Region decode on `req_addr[31:28]`:
  - 4'b0001 or 4'b0011 → DMEM.
  - 4'b0100 → BIOS.
  - 4'b1000 → MMIO (see Configuration).
  - Any other value → region error.
- Captured per accepted request: funct3, addr[1:0], region, misaligned flag.
- Misaligned means either of:
  - LH/LHU with addr[0]=1.
  - LW with addr[1:0]≠0.
- Funct3 011, 110 and 111 are treated as LW.
- Extraction from the selected word W:
  - LB/LBU: byte W[8·addr[1:0]+7 : 8·addr[1:0]], sign-extended from bit 7 (LB) or zero-extended (LBU).
  - LH/LHU: W[31:16] if addr[1]=1, else W[15:0], sign-extended from bit 15 (LH) or zero-extended (LHU).
  - LW: W unchanged.
- Priority: misaligned > region_err > data. When either flag is set, load_data = 0.
- State machine (states IDLE, RESP, HOLD):
  - IDLE: outputs all 0. `req_valid & !stall` → capture, go to RESP. Otherwise stay.
  - RESP: load_valid=1; load_data formatted combinationally from the live RAM outputs.
    - `stall` → copy formatted data and flags into the hold register, go to HOLD.
    - `!stall & req_valid` → capture the new request, stay in RESP.
    - Otherwise → IDLE.
  - HOLD: load_valid=1; outputs from the hold register.
    - `stall` → stay.
    - `!stall & req_valid` → capture, go to RESP.
    - `!stall & !req_valid` → IDLE.
- Requests arriving while `stall`=1 are ignored in every state; the pipeline re-presents them.
- Outputs are 0 whenever load_valid=0.

## Timing
- Reset: state IDLE; load_valid, load_data, misaligned and region_err all 0; capture and hold registers cleared.
- Latency: request accepted at edge N → result valid in cycle N+1, combinational from the RAM outputs in that cycle.
- Back-to-back loads: one result per cycle, no bubbles.
- Stall during RESP: the value shown in the first stalled cycle persists bit-exact for every further stalled cycle, even if RAM outputs change.
- `rst` asserted in any state: returns to IDLE at that edge and overrides `req_valid`. Outputs are 0 in the following cycle.

## Configuration
- `LOAD_MMIO_EN` defined:
  - Region 4'b1000 selects `mmio_dout`.
- `LOAD_MMIO_EN` undefined:
  - Region 4'b1000 is a region error.
  - `mmio_dout` is ignored; no MMIO mux logic is generated.

## Test plan
- LB at 0x10000003 with dmem_dout=0x80FF7F01 → cycle N+1: load_valid=1, load_data=0xFFFFFF80. Same load as LBU → 0x00000080.
- LH at 0x40000002 with bios_dout=0x8001ABCD → 0xFFFF8001. LHU at 0x40000000 → 0x0000ABCD.
- LW at 0x10000002 → misaligned=1, load_data=0. LW at 0x20000000 → region_err=1, load_data=0.
- LW at 0x10000000 returning 0x12345678, then stall held 3 cycles while dmem_dout changes to 0xDEADBEEF → load_data stays 0x12345678 through the stall. load_valid drops the cycle after stall clears with no new request.
- Back-to-back LW at 0x10000000 and 0x10000004 (data 0x11111111, 0x22222222) → consecutive valid results with no gap. `rst` asserted with a request pending → next cycle all outputs 0.
- LW at 0x80000000, mmio_dout=0x0000005A → with LOAD_MMIO_EN: load_data=0x0000005A. Without LOAD_MMIO_EN: region_err=1, load_data=0.
